// File: rtl/mcpu_bus_pkg.sv
// Shared definitions for the CPU external-bus responder: FSM states, IO page map,
// default wait-state count.
package mcpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  // Top nibble of the byte address that selects the IO page.
  localparam logic [3:0] IO_PAGE = 4'hF;

  // Word offsets inside the IO page (byte address bits [3:2]).
  localparam logic [1:0] IO_LED = 2'd0;
  localparam logic [1:0] IO_SW  = 2'd1;
  localparam logic [1:0] IO_CYC = 2'd2;

  localparam int DEFAULT_WAIT_CYCLES = 2;

endpackage

// File: rtl/mcpu_mem_responder_if.sv
// CPU-side request/response bus: strobe, direction, address, data, completion pulse.
interface mcpu_mem_responder_if;
  logic        cpu_mio;
  logic        mem_w;
  logic [31:0] addr_in;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        mio_ready;

  modport master (
    output cpu_mio, mem_w, addr_in, data_in,
    input  data_out, mio_ready
  );

  modport slave (
    input  cpu_mio, mem_w, addr_in, data_in,
    output data_out, mio_ready
  );
endinterface

// File: rtl/mcpu_sram_sp.sv
// Single-port word RAM: synchronous write, asynchronous read.
module mcpu_sram_sp #(
  parameter int ADDR_W    = 10,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  // NOTE: the array has no reset; contents survive reset and start undefined.
  logic [31:0] mem_q [2**ADDR_W];

  // Write port: one word per enabled edge.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mcpu_mem_responder.sv
// Memory/IO responder for the multi-cycle CPU bus: one request at a time, RAM plus
// a small IO page (LEDs, synchronised switches, free-running cycle counter), each
// access completed by a one-cycle mio_ready pulse after WAIT_CYCLES wait states.
module mcpu_mem_responder
  import mcpu_bus_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter     INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  mcpu_mem_responder_if.slave   bus,
  input  logic [15:0]           sw_in,
  output logic [15:0]           led_out
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        commit;

  logic [15:0] led_q;
  logic [31:0] cyc_q;
  logic [15:0] sw_meta_q, sw_sync_q;
  logic [31:0] data_out_q;

  // Access fields seen at the commit edge: straight from the bus when the request
  // commits on its own sampling edge (zero wait states), otherwise the latched copy.
  logic [29:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic              acc_we;
  logic              is_ram, is_io;
  logic [1:0]        io_off;
  logic [31:0]       ram_rdata;
  logic [31:0]       rd_val;
  logic              ram_we;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^bus.addr_in[1:0];

  // Next-state logic for the request FSM; commit flags the edge entering READY.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_mio) begin
          addr_d  = bus.addr_in[31:2];
          wdata_d = bus.data_in;
          we_d    = bus.mem_w;
          wcnt_d  = WAIT_LD;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_READY;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q <= 4'd1) begin
          state_d = ST_READY;
          commit  = 1'b1;
        end
      end
      ST_READY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM and latched request registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update
    // together from pre-edge values.
    if (reset) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  // Address decode and read-data selection for the access being committed.
  always_comb begin
    acc_addr  = (state_q == ST_IDLE) ? bus.addr_in[31:2] : addr_q;
    acc_wdata = (state_q == ST_IDLE) ? bus.data_in       : wdata_q;
    acc_we    = (state_q == ST_IDLE) ? bus.mem_w         : we_q;
    is_ram    = (acc_addr[29:ADDR_W] == '0);
    is_io     = (acc_addr[29:26] == IO_PAGE);
    io_off    = acc_addr[1:0];
    rd_val    = 32'h0;
    if (is_ram) begin
      rd_val = ram_rdata;
    end else if (is_io) begin
      case (io_off)
        IO_LED:  rd_val = {16'h0, led_q};
        IO_SW:   rd_val = {16'h0, sw_sync_q};
        IO_CYC:  rd_val = cyc_q;
        default: rd_val = 32'h0;
      endcase
    end
  end

  // A commit coinciding with a reset edge must not reach the RAM.
  assign ram_we = commit && acc_we && is_ram && !reset;

  mcpu_sram_sp #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_sram (
    .clk     (clk),
    .we_i    (ram_we),
    .idx_i   (acc_addr[ADDR_W-1:0]),
    .wdata_i (acc_wdata),
    .rdata_o (ram_rdata)
  );

  // IO registers, switch synchroniser and the read-data holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q      <= '0;
      cyc_q      <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      data_out_q <= '0;
    end else begin
      sw_meta_q <= sw_in;
      sw_sync_q <= sw_meta_q;
      if (commit && acc_we && is_io && io_off == IO_CYC) cyc_q <= '0;
      else                                              cyc_q <= cyc_q + 32'd1;
      if (commit && acc_we && is_io && io_off == IO_LED) led_q <= acc_wdata[15:0];
      if (commit && !acc_we) data_out_q <= rd_val;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.mio_ready = (state_q == ST_READY);
  assign led_out       = led_q;

endmodule

// File: tb/tb_mcpu_mem_responder.sv
// Self-checking bench: directed scenarios plus randomised traffic, compared every
// cycle against a transaction-level model of the responder.
module tb_mcpu_mem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sw = 16'h0;
  logic [15:0] led;
  logic [15:0] led0;

  always #5 clk = ~clk;

  mcpu_mem_responder_if bus ();
  mcpu_mem_responder_if bus0 ();

  mcpu_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(W), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .bus(bus), .sw_in(sw), .led_out(led)
  );

  mcpu_mem_responder #(.ADDR_W(4), .WAIT_CYCLES(0), .INIT_FILE("")) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .sw_in(16'h0), .led_out(led0)
  );

  int          total = 0;
  int          bad = 0;
  int          tcyc = 0;       // rising edges since reset release
  int          ready_cyc = -100;
  int          cyc_clear = 0;  // edge index of the last CYC clear (0 = reset)
  bit          chk_en = 1'b0;
  logic [31:0] exp_data = 32'h0;
  logic [15:0] exp_led = 16'h0;
  logic [31:0] ram_m [int];
  logic [31:0] pool [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) if (!reset) tcyc++;

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("mio_ready", {31'h0, bus.mio_ready}, {31'h0, (tcyc == ready_cyc)});
      check("data_out", bus.data_out, exp_data);
      check("led_out", {16'h0, led}, {16'h0, exp_led});
    end
  end

  // Transaction-level effect of an access committed at edge k.
  task automatic model_commit(input bit we, input logic [31:0] a, input logic [31:0] d,
                              input int k);
    if (a[31:12] == 20'h0) begin
      if (we) ram_m[int'(a[11:2])] = d;
      else    exp_data = ram_m.exists(int'(a[11:2])) ? ram_m[int'(a[11:2])] : 32'hx;
    end else if (a[31:28] == 4'hF) begin
      case (a[3:2])
        2'd0:    if (we) exp_led = d[15:0]; else exp_data = {16'h0, exp_led};
        2'd1:    if (!we) exp_data = {16'h0, sw};
        2'd2:    if (we) cyc_clear = k; else exp_data = 32'(k - 1 - cyc_clear);
        default: if (!we) exp_data = 32'h0;
      endcase
    end else if (!we) begin
      exp_data = 32'h0;
    end
  endtask

  // One request on the W-wait-state DUT; returns data_out seen in the ready cycle.
  task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input bit keep, output logic [31:0] rd);
    int t0;
    @(posedge clk); #1;
    bus.cpu_mio = 1'b1; bus.mem_w = we; bus.addr_in = a; bus.data_in = d;
    @(posedge clk); #1;
    t0 = tcyc;
    ready_cyc = t0 + W;
    while (tcyc < ready_cyc) begin
      bus.mem_w = 1'($urandom_range(0, 1)); bus.addr_in = $urandom; bus.data_in = $urandom;
      @(posedge clk); #1;
    end
    model_commit(we, a, d, tcyc);
    rd = bus.data_out;
    bus.cpu_mio = keep;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, rd2;
    bit          keep, prev_keep;
    bus.cpu_mio = 0; bus.mem_w = 0; bus.addr_in = 0; bus.data_in = 0;
    bus0.cpu_mio = 0; bus0.mem_w = 0; bus0.addr_in = 0; bus0.data_in = 0;
    pool[0] = 32'h0;        pool[1] = 32'h4;        pool[2] = 32'h8;        pool[3] = 32'h1C;
    pool[4] = 32'h20;       pool[5] = 32'hFFC;      pool[6] = 32'h10;       pool[7] = 32'h14;
    pool[8] = 32'hF0000000; pool[9] = 32'hF0000004; pool[10] = 32'hF0000008;
    pool[11] = 32'hF000000C; pool[12] = 32'hF0001000; pool[13] = 32'h40000000;
    pool[14] = 32'h00001000; pool[15] = 32'h7FFFFFF0;

    repeat (3) @(posedge clk);
    #1;
    check("rst mio_ready", {31'h0, bus.mio_ready}, 32'h0);
    check("rst data_out", bus.data_out, 32'h0);
    check("rst led_out", {16'h0, led}, 32'h0);
    @(negedge clk); reset = 1'b0; tcyc = 0; cyc_clear = 0;
    @(posedge clk); #1; chk_en = 1'b1;

    // 1: RAM write then read.
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rd);
    do_req(1'b0, 32'h10, 32'h0, 1'b0, rd);
    check("ram readback", rd, 32'hDEADBEEF);

    // 2: LED write, switch read.
    do_req(1'b1, 32'hF0000000, 32'h0000A5A5, 1'b0, rd);
    check("led write", {16'h0, led}, 32'h0000A5A5);
    sw = 16'h1234;
    repeat (3) @(posedge clk);
    do_req(1'b0, 32'hF0000004, 32'h0, 1'b0, rd);
    check("sw read", rd, 32'h00001234);

    // 3: cycle counter. Reads 10 idle edges apart commit 10+1+1+W = 14 edges apart.
    do_req(1'b0, 32'hF0000008, 32'h0, 1'b0, rd);
    repeat (10) @(posedge clk);
    do_req(1'b0, 32'hF0000008, 32'h0, 1'b0, rd2);
    check("cyc delta", rd2 - rd, 32'd14);
    do_req(1'b1, 32'hF0000008, 32'hFFFF0000, 1'b0, rd);
    do_req(1'b0, 32'hF0000008, 32'h0, 1'b0, rd);
    check("cyc after clear", rd, 32'd3);

    // 4: unmapped accesses.
    do_req(1'b0, 32'h40000000, 32'h0, 1'b0, rd);
    check("unmapped read", rd, 32'h0);
    do_req(1'b1, 32'h40000000, 32'hFFFFFFFF, 1'b0, rd);
    do_req(1'b0, 32'h10, 32'h0, 1'b0, rd);
    check("ram untouched", rd, 32'hDEADBEEF);
    do_req(1'b0, 32'hF0000000, 32'h0, 1'b0, rd);
    check("led untouched", rd, 32'h0000A5A5);

    // 5: back-to-back with cpu_mio held across READY.
    do_req(1'b1, 32'h14, 32'h00000055, 1'b1, rd);
    do_req(1'b0, 32'h14, 32'h0, 1'b0, rd);
    check("b2b read", rd, 32'h00000055);

    // 6: reset in the middle of a write.
    do_req(1'b1, 32'h20, 32'h11112222, 1'b0, rd);
    @(posedge clk); #1;
    bus.cpu_mio = 1'b1; bus.mem_w = 1'b1; bus.addr_in = 32'h20; bus.data_in = 32'h99999999;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_en = 1'b0; reset = 1'b1; bus.cpu_mio = 1'b0;
    ready_cyc = -100; exp_data = 32'h0; exp_led = 16'h0;
    #1;
    check("abort mio_ready", {31'h0, bus.mio_ready}, 32'h0);
    check("abort data_out", bus.data_out, 32'h0);
    check("abort led_out", {16'h0, led}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0; tcyc = 0; cyc_clear = 0;
    @(posedge clk); #1; chk_en = 1'b1;
    do_req(1'b0, 32'h20, 32'h0, 1'b0, rd);
    check("abort no write", rd, 32'h11112222);

    // Random traffic over RAM, IO, aliases and unmapped space.
    for (int i = 0; i < 8; i++) do_req(1'b1, pool[i], $urandom, 1'b0, rd);
    prev_keep = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!prev_keep && $urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
        sw = 16'($urandom);
        repeat (3) @(posedge clk);
      end
      keep = ($urandom_range(0, 3) == 0) && (i != 299);
      do_req(1'($urandom_range(0, 1)), pool[$urandom_range(0, 15)] | 32'($urandom_range(0, 3)),
             $urandom, keep, rd);
      prev_keep = keep;
    end

    // Zero-wait-state build: ready in the cycle right after the request edge.
    @(posedge clk); #1;
    bus0.cpu_mio = 1'b1; bus0.mem_w = 1'b1; bus0.addr_in = 32'h4; bus0.data_in = 32'hCAFEF00D;
    @(posedge clk); #1;
    check("w0 write ready", {31'h0, bus0.mio_ready}, 32'h1);
    bus0.cpu_mio = 1'b0;
    @(posedge clk); #1;
    check("w0 idle", {31'h0, bus0.mio_ready}, 32'h0);
    bus0.cpu_mio = 1'b1; bus0.mem_w = 1'b0; bus0.data_in = 32'h0;
    @(posedge clk); #1;
    check("w0 read ready", {31'h0, bus0.mio_ready}, 32'h1);
    check("w0 read data", bus0.data_out, 32'hCAFEF00D);
    @(posedge clk); #1;
    check("w0 held idle", {31'h0, bus0.mio_ready}, 32'h0);
    @(posedge clk); #1;
    check("w0 b2b ready", {31'h0, bus0.mio_ready}, 32'h1);
    check("w0 b2b data", bus0.data_out, 32'hCAFEF00D);
    bus0.cpu_mio = 1'b0;

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
